pipe_hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage MIPS core. Decides each cycle whether the PC and IF/ID advance, and whether IF/ID is flushed or a bubble is injected into ID/EX. Covers load-use hazards, taken-branch flush and the multi-cycle mult/div unit's busy window. Keeps a saturating stall-cycle counter for performance debug.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 52 +++++
 rtl/pipe_hazard_ctrl_md_busy_timer.sv | 79 +++++++
 rtl/pipe_hazard_ctrl.sv | 113 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared pipeline sequencing types and constants
//
// Purpose:
//   Types and constants shared by the hazard controller and the pipeline
//   registers it steers:
//   - the mult/div sequencing state;
//   - the register-zero address;
//   - the stall/flush control bundle;
//   - a helper that matches a source operand against a destination register.
package pipe_hazard_ctrl_pkg;

  // Width of the mult/div busy down-counter. MD_LATENCY is legal from 2 to 255.
  localparam int MD_CNT_W = 8;

  // $zero is never a real producer, so it can never cause a load-use stall.
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // Control bundle consumed by the PC, IF/ID and ID/EX registers.
  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
  } pipe_ctrl_t;

  // Normal advance: the PC and IF/ID load, and no bubble is inserted.
  localparam pipe_ctrl_t CTRL_RUN    = '{pc_write: 1'b1, ifid_write: 1'b1,
                                         ifid_flush: 1'b0, idex_bubble: 1'b0};
  // Stall: the PC and IF/ID hold, and ID/EX takes a bubble.
  localparam pipe_ctrl_t CTRL_STALL  = '{pc_write: 1'b0, ifid_write: 1'b0,
                                         ifid_flush: 1'b0, idex_bubble: 1'b1};
  // Taken branch: fetch the target and squash the wrong-path instruction
  // in both IF/ID and ID/EX.
  localparam pipe_ctrl_t CTRL_FLUSH  = '{pc_write: 1'b1, ifid_write: 1'b1,
                                         ifid_flush: 1'b1, idex_bubble: 1'b1};
  // Held in reset: nothing advances, and both pipeline registers hold NOPs.
  localparam pipe_ctrl_t CTRL_RESET  = '{pc_write: 1'b0, ifid_write: 1'b0,
                                         ifid_flush: 1'b1, idex_bubble: 1'b1};

  // True when an operand the ID instruction actually reads names register dst.
  function automatic logic src_match(input logic       uses,
                                     input logic [4:0] src,
                                     input logic [4:0] dst);
    return uses && (src == dst);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_md_busy_timer.sv
// rtl/pipe_hazard_ctrl_md_busy_timer.sv - mult/div busy window timer
//
// Purpose:
//   Tracks the multi-cycle mult/div unit. Once issued, the unit stays busy
//   for MD_LATENCY cycles. done pulses on the last of those cycles.
//   An abort drops the operation immediately and produces no done pulse.
//
// Ports:
//   clk    in   core clock
//   start  in   issue a mult/div (ignored while busy)
//   abort  in   synchronous abandon/reset; also masks busy/done combinationally
//   busy   out  mult/div in progress
//   done   out  one-cycle pulse on the last busy cycle
module pipe_hazard_ctrl_md_busy_timer
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MD_LATENCY = 32
) (
  input  logic clk,
  input  logic start,
  input  logic abort,
  output logic busy,
  output logic done
);

  // The counter is loaded with LATENCY-1 so that it reaches zero on the
  // LATENCY-th busy cycle, which is also the done cycle.
  localparam logic [MD_CNT_W-1:0] CNT_LOAD = MD_CNT_W'(MD_LATENCY - 1);

  md_state_e           r_st;
  md_state_e           w_st_nxt;
  logic [MD_CNT_W-1:0] r_cnt;
  logic [MD_CNT_W-1:0] w_cnt_nxt;

  always_ff @(posedge clk) begin
    if (abort) begin
      r_st  <= RUN;
      r_cnt <= '0;
    end else begin
      r_st  <= w_st_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_st_nxt  = r_st;
    w_cnt_nxt = r_cnt;
    busy      = 1'b0;
    done      = 1'b0;
    case (r_st)
      RUN: begin
        if (start) begin
          w_st_nxt  = MD_BUSY;
          w_cnt_nxt = CNT_LOAD;
        end
      end
      MD_BUSY: begin
        busy = 1'b1;
        if (r_cnt == '0) begin
          done     = 1'b1;
          w_st_nxt = RUN;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_st_nxt  = RUN;
        w_cnt_nxt = '0;
      end
    endcase
    // While aborting, the register still shows the old state. Hide it so
    // that reset cannot leak a late done pulse.
    if (abort) begin
      busy = 1'b0;
      done = 1'b0;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - 5-stage pipeline sequencing / hazard controller
//
// Purpose:
//   Decides each cycle whether the PC and IF/ID advance, whether IF/ID is
//   flushed, and whether a bubble goes into ID/EX. It handles three cases:
//   - load-use hazards;
//   - taken-branch flushes;
//   - the mult/div busy window.
//   It also counts stalled cycles in a saturating counter for debug.
//
// Ports:
//   clk, rst                     clock; synchronous active-high reset
//   id_rs_addr/id_rt_addr        source register fields of the ID instruction
//   id_uses_rs/id_uses_rt        the ID instruction really reads Rs/Rt
//   id_md_start                  the ID instruction is mult/multu/div/divu
//   id_reads_hilo                the ID instruction is mfhi/mflo
//   ex_memread, ex_rt_addr       load in EX and its destination register
//   ex_branch_taken              branch/jump in EX resolved taken
//   pc_write, ifid_write         advance enables
//   ifid_flush, idex_bubble      squash controls
//   md_busy, md_done             mult/div window and last-cycle pulse
//   stall_cycles                 saturating count of cycles with pc_write = 0
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MD_LATENCY = 32,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs_addr,
  input  logic [4:0]       id_rt_addr,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_md_start,
  input  logic             id_reads_hilo,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt_addr,
  input  logic             ex_branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             w_lu_haz;
  logic             w_md_haz;
  logic             w_md_start;
  logic             w_md_busy;
  logic             w_md_done;
  pipe_ctrl_t       w_ctrl;
  logic [CNT_W-1:0] r_stall_cycles;

  // A load's result is not ready for an ID consumer until the load leaves
  // EX, so any real operand match stalls for exactly one cycle.
  assign w_lu_haz = ex_memread && (ex_rt_addr != REG_ZERO) &&
                    (src_match(id_uses_rs, id_rs_addr, ex_rt_addr) ||
                     src_match(id_uses_rt, id_rt_addr, ex_rt_addr));

  // HI/LO readers and a second mult/div wait for the whole busy window,
  // including the done cycle, so that they issue the cycle after it.
  assign w_md_haz = w_md_busy && (id_reads_hilo || id_md_start);

  // A wrong-path instruction (branch taken) or one that is about to stall
  // (load-use) must not start the unit. The timer ignores start while busy.
  assign w_md_start = id_md_start && !ex_branch_taken && !w_lu_haz;

  pipe_hazard_ctrl_md_busy_timer #(
    .MD_LATENCY (MD_LATENCY)
  ) u_md_timer (
    .clk   (clk),
    .start (w_md_start),
    .abort (rst),
    .busy  (w_md_busy),
    .done  (w_md_done)
  );

  always_comb begin
    w_ctrl = CTRL_RUN;
    if (rst) begin
      w_ctrl = CTRL_RESET;
    end else if (ex_branch_taken) begin
      // The branch outranks hazards on the instruction it squashes.
      w_ctrl = CTRL_FLUSH;
    end else if (w_lu_haz || w_md_haz) begin
      w_ctrl = CTRL_STALL;
    end
  end

  // Saturates instead of wrapping, so a long-running count stays meaningful.
  // Cycles spent in reset are not counted because the counter is held clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if (!w_ctrl.pc_write && (r_stall_cycles != CNT_MAX)) begin
      r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end

  assign pc_write     = w_ctrl.pc_write;
  assign ifid_write   = w_ctrl.ifid_write;
  assign ifid_flush   = w_ctrl.ifid_flush;
  assign idex_bubble  = w_ctrl.idex_bubble;
  assign md_busy      = w_md_busy;
  assign md_done      = w_md_done;
  assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs_addr;
  logic [4:0] id_rt_addr;
  logic       id_uses_rs;
  logic       id_uses_rt;
  logic       id_md_start;
  logic       id_reads_hilo;
  logic       ex_memread;
  logic [4:0] ex_rt_addr;
  logic       ex_branch_taken;
  logic       pc_write;
  logic       ifid_write;
  logic       ifid_flush;
  logic       idex_bubble;
  logic       md_busy;
  logic       md_done;
  logic [1:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .MD_LATENCY (4),
    .CNT_W      (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs_addr      (id_rs_addr),
    .id_rt_addr      (id_rt_addr),
    .id_uses_rs      (id_uses_rs),
    .id_uses_rt      (id_uses_rt),
    .id_md_start     (id_md_start),
    .id_reads_hilo   (id_reads_hilo),
    .ex_memread      (ex_memread),
    .ex_rt_addr      (ex_rt_addr),
    .ex_branch_taken (ex_branch_taken),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .ifid_flush      (ifid_flush),
    .idex_bubble     (idex_bubble),
    .md_busy         (md_busy),
    .md_done         (md_done),
    .stall_cycles    (stall_cycles)
  );

  // {pc_write, ifid_write, ifid_flush, idex_bubble}
  localparam logic [3:0] C_RUN   = 4'b1100;
  localparam logic [3:0] C_STALL = 4'b0001;
  localparam logic [3:0] C_FLUSH = 4'b1111;
  localparam logic [3:0] C_RESET = 4'b0011;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and let outputs settle away from the edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    id_rs_addr = 5'd0; id_rt_addr = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    id_md_start = 1'b0; id_reads_hilo = 1'b0; ex_memread = 1'b0;
    ex_rt_addr = 5'd0; ex_branch_taken = 1'b0;
  endtask

  task automatic lu_hazard_rs8();
    ex_memread = 1'b1; ex_rt_addr = 5'd8; id_uses_rs = 1'b1; id_rs_addr = 5'd8;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    #2;
    chk("reset_ctrl", {pc_write, ifid_write, ifid_flush, idex_bubble}, C_RESET);
    chk("reset_md_busy", md_busy, 1'b0);
    chk("reset_md_done", md_done, 1'b0);
    step();
    chk("reset_stall_cnt", stall_cycles, 2'd0);
    rst = 1'b0;
    #1;
    chk("idle_ctrl", {pc_write, ifid_write, ifid_flush, idex_bubble}, C_RUN);

    // Load-use on Rs: one stall cycle, then the bubble clears ex_memread.
    lu_hazard_rs8();
    #1;
    chk("lu_rs_stall", {pc_write, ifid_write, ifid_flush, idex_bubble}, C_STALL);
    step();
    ex_memread = 1'b0;
    #1;
    chk("lu_release", {pc_write, ifid_write, ifid_flush, idex_bubble}, C_RUN);
    chk("lu_stall_cnt", stall_cycles, 2'd1);

    // $zero is never a hazard.
    idle_inputs();
    ex_memread = 1'b1; id_uses_rs = 1'b1;
    #1;
    chk("zero_no_stall", {pc_write, ifid_write, ifid_flush, idex_bubble}, C_RUN);
    step();

    // Rt matches but is not read: no hazard.
    idle_inputs();
    ex_memread = 1'b1; ex_rt_addr = 5'd9; id_rt_addr = 5'd9;
    #1;
    chk("rt_unused_no_stall", {pc_write, ifid_write, ifid_flush, idex_bubble}, C_RUN);
    step();

    // A taken branch beats the load-use hazard.
    idle_inputs();
    lu_hazard_rs8();
    ex_branch_taken = 1'b1;
    #1;
    chk("branch_beats_lu", {pc_write, ifid_write, ifid_flush, idex_bubble}, C_FLUSH);
    step();
    chk("branch_stall_cnt", stall_cycles, 2'd1);

    // Load-use on Rt.
    idle_inputs();
    ex_memread = 1'b1; ex_rt_addr = 5'd9; id_uses_rt = 1'b1; id_rt_addr = 5'd9;
    #1;
    chk("lu_rt_stall", {pc_write, ifid_write, ifid_flush, idex_bubble}, C_STALL);
    step();
    chk("lu_rt_stall_cnt", stall_cycles, 2'd2);

    // Mult/div issued on the wrong path must not start the unit.
    idle_inputs();
    id_md_start = 1'b1; ex_branch_taken = 1'b1;
    #1;
    chk("branch_md_ctrl", {pc_write, ifid_write, ifid_flush, idex_bubble}, C_FLUSH);
    step();
    idle_inputs();
    #1;
    chk("branch_md_not_busy", md_busy, 1'b0);
    chk("branch_md_ctrl_after", {pc_write, ifid_write, ifid_flush, idex_bubble}, C_RUN);

    // Reset the counter, then mult followed by mfhi with MD_LATENCY = 4.
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle_inputs();
    id_md_start = 1'b1;
    #1;
    chk("md_issue_ctrl", {pc_write, ifid_write, ifid_flush, idex_bubble}, C_RUN);
    chk("md_issue_not_busy", md_busy, 1'b0);
    chk("md_issue_stall_cnt", stall_cycles, 2'd0);
    step();
    id_md_start = 1'b0; id_reads_hilo = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk($sformatf("md_busy_c%0d", i), md_busy, 1'b1);
      chk($sformatf("md_done_c%0d", i), md_done, (i == 4) ? 1'b1 : 1'b0);
      chk($sformatf("md_ctrl_c%0d", i),
          {pc_write, ifid_write, ifid_flush, idex_bubble}, C_STALL);
      step();
    end
    #1;
    chk("mfhi_issue_ctrl", {pc_write, ifid_write, ifid_flush, idex_bubble}, C_RUN);
    chk("mfhi_not_busy", md_busy, 1'b0);
    chk("mfhi_no_done", md_done, 1'b0);
    // Four stalls with a 2-bit counter saturate at 3.
    chk("sat_after_4", stall_cycles, 2'd3);
    idle_inputs();
    lu_hazard_rs8();
    step();
    chk("sat_after_5", stall_cycles, 2'd3);

    // Back-to-back mult/div, then reset on the 2nd busy cycle.
    idle_inputs();
    id_md_start = 1'b1;
    step();
    #1;
    chk("b2b_busy_c1", md_busy, 1'b1);
    chk("b2b_stall_c1", {pc_write, ifid_write, ifid_flush, idex_bubble}, C_STALL);
    step();
    id_md_start = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_mid_ctrl", {pc_write, ifid_write, ifid_flush, idex_bubble}, C_RESET);
    chk("rst_mid_busy", md_busy, 1'b0);
    step();
    rst = 1'b0;
    #1;
    chk("post_rst_busy", md_busy, 1'b0);
    chk("post_rst_stall_cnt", stall_cycles, 2'd0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("post_rst_no_done_%0d", i), md_done, 1'b0);
      step();
    end
    chk("post_rst_idle_busy", md_busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
